tm1638_responder: RTL
=====================

// Module: tm1638_responder
// PURPOSE
//  Target-side model of the TM1638 3-wire serial link (STB/CLK/DIO): decodes host command/data
//  frames into a 16-byte display RAM plus display-control state, and shifts 4 key-scan bytes back
//  on read frames. Used as a bench model and as a panel emulator on a second board.
// PARAMETERS
//  SYNC_STAGES  2   flops per input synchronizer on tm_stb/tm_clk/tm_dio_in (min 2)
//  KEY_BYTES    4   bytes returned per read frame
// PORTS
//  clk          in   1   system clock, >= 8x tm_clk rate
//  reset        in   1   synchronous, active-high
//  tm_stb       in   1   strobe from host, active low, async
//  tm_clk       in   1   serial clock from host, idles high, async
//  tm_dio_in    in   1   DIO sampled from pad, async
//  tm_dio_out   out  1   DIO drive value
//  tm_dio_oe    out  1   1 = responder drives DIO
//  keys         in   8*KEY_BYTES  key-scan bytes; byte0 = keys[7:0]
//  rd_addr      in   4   display RAM read address
//  rd_data      out  8   display RAM read data, registered (1-cycle latency)
//  display_on   out  1   display-control bit3
//  brightness   out  3   display-control bits[2:0]
//  frame_done   out  1   1-cycle pulse: tm_stb rose after >=1 complete byte
//  cmd_error    out  1   1-cycle pulse: first byte of frame has [7:6]=00
// BEHAVIOUR
//  - Reset: RAM all 0x00, display_on=0, brightness=0, addr=0, mode=write/auto-inc, state=IDLE,
//    tm_dio_oe=0, tm_dio_out=1, rd_data=0x00, pulses=0.
//  - Edges detected on synchronized signals; edge latency SYNC_STAGES+1 clk.
//  - States: IDLE -> CMD (tm_stb fall) -> WDATA | RDATA | DRAIN; any state -> IDLE on tm_stb rise.
//  - Bit capture: on tm_clk rise, LSB first; byte complete at 8th bit.
//  - CMD byte decode:
//    01xxxxxx data cmd: bit1=1 read -> RDATA; else store mode (bit2=1 fixed addr, 0 auto-inc) -> DRAIN.
//    10xxxxxx display ctl: display_on<=b[3], brightness<=b[2:0] -> DRAIN.
//    11xxxxxx address set: addr<=b[3:0] -> WDATA.
//    00xxxxxx: cmd_error pulse -> DRAIN.
//  - WDATA: each byte writes ram[addr]; auto-inc: addr<=addr+1 mod 16 (15 wraps to 0);
//    fixed: addr unchanged.
//  - DRAIN: further bits/bytes ignored until tm_stb rise.
//  - RDATA:
//    On entry, keys snapshotted; tm_dio_oe=1.
//    On each tm_clk fall, tm_dio_out<=next snapshot bit (LSB of byte0 first).
//    After 8*KEY_BYTES bits: tm_dio_oe=0, tm_dio_out=1, rest of frame ignored.
//  - tm_stb rise: partial byte discarded, tm_dio_oe<=0, tm_dio_out<=1. Bytes completed
//    earlier keep their effect.
//  - Same-cycle tm_stb rise and tm_clk edge: stb wins, bit dropped. tm_stb fall with no prior
//    rise (reset mid-frame) starts a fresh frame.
//  - RAM port: write and read of same address in one cycle -> rd_data returns old value.
//  - Mode and addr persist across frames; display ctl only changes on 10xxxxxx.
// CONFIGURATION
//  TM1638_RESP_GLITCH_FILTER_EN defined:
//    tm_stb/tm_clk pass a 3-sample majority filter after sync; edge latency +2 clk.
//    A single-clk pulse on either line is rejected.
//  Not defined: no filter; a pulse surviving the synchronizer is treated as an edge.
// TESTING
//  - Reset, then idle 100 clk -> all outputs at reset values, tm_dio_oe=0.
//  - Frame 0x40; then frame 0xC0,0x06,0x5B,0x4F -> ram[0..2]=06,5B,4F, addr=3, frame_done x2.
//  - Frame 0x44; then frame 0xCF,0x11,0x22 -> ram[15]=0x22, ram[0] unchanged (fixed addr).
//  - Frame 0x40; then 0xCE,0xAA,0xBB,0xCC -> ram[14]=AA, ram[15]=BB, ram[0]=CC (wrap).
//  - keys=32'h8000_0201, frame 0x42 + 32 clocks -> DIO bits 1,0,0,0,0,0,0,0,0,1,...,
//    last bit 1; oe drops after bit 32.
//  - Frame 0x8C -> display_on=1, brightness=4.
//  - Frame 0x12 -> cmd_error pulse, RAM unchanged.
//  - Frame 0xC0,0x3 bits then tm_stb high -> ram[0] unchanged.

Source files
------------

// File: rtl/tm1638_responder.sv
// Target side of the TM1638 STB/CLK/DIO link: decodes host frames into a 16-byte display RAM
// plus display control and shifts key-scan bytes back. Optional TM1638_RESP_GLITCH_FILTER_EN.
module tm1638_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned KEY_BYTES   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tm_stb,
  input  logic                   tm_clk,
  input  logic                   tm_dio_in,
  output logic                   tm_dio_out,
  output logic                   tm_dio_oe,
  input  logic [8*KEY_BYTES-1:0] keys,
  input  logic [3:0]             rd_addr,
  output logic [7:0]             rd_data,
  output logic                   display_on,
  output logic [2:0]             brightness,
  output logic                   frame_done,
  output logic                   cmd_error
);

  localparam int unsigned NumKeyBits = 8 * KEY_BYTES;
  localparam int unsigned RdCntW     = $clog2(NumKeyBits + 1);

  typedef enum logic [2:0] {StIdle, StCmd, StWdata, StRdata, StDrain} state_e;

  // Synchronizers reset to the idle-high level so reset itself never looks like an edge.
  logic [SYNC_STAGES-1:0] stb_sync_q, clk_sync_q, dio_sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stb_sync_q <= '1;
      clk_sync_q <= '1;
      dio_sync_q <= '1;
    end else begin
      stb_sync_q <= {stb_sync_q[SYNC_STAGES-2:0], tm_stb};
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], tm_clk};
      dio_sync_q <= {dio_sync_q[SYNC_STAGES-2:0], tm_dio_in};
    end
  end

  logic stb_f, clk_f, dio_f;

`ifdef TM1638_RESP_GLITCH_FILTER_EN
  logic [2:0] stb_win_q, clk_win_q;
  logic [1:0] dio_dly_q;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  // DIO is delayed by the same two clocks so it stays aligned with the filtered clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      stb_win_q <= '1;
      clk_win_q <= '1;
      dio_dly_q <= '1;
    end else begin
      stb_win_q <= {stb_win_q[1:0], stb_sync_q[SYNC_STAGES-1]};
      clk_win_q <= {clk_win_q[1:0], clk_sync_q[SYNC_STAGES-1]};
      dio_dly_q <= {dio_dly_q[0], dio_sync_q[SYNC_STAGES-1]};
    end
  end

  assign stb_f = maj3(stb_win_q);
  assign clk_f = maj3(clk_win_q);
  assign dio_f = dio_dly_q[1];
`else
  assign stb_f = stb_sync_q[SYNC_STAGES-1];
  assign clk_f = clk_sync_q[SYNC_STAGES-1];
  assign dio_f = dio_sync_q[SYNC_STAGES-1];
`endif

  logic stb_prev_q, clk_prev_q;
  logic stb_rise, stb_fall, clk_rise, clk_fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      stb_prev_q <= 1'b1;
      clk_prev_q <= 1'b1;
    end else begin
      stb_prev_q <= stb_f;
      clk_prev_q <= clk_f;
    end
  end

  assign stb_rise = stb_f & ~stb_prev_q;
  assign stb_fall = ~stb_f & stb_prev_q;
  assign clk_rise = clk_f & ~clk_prev_q;
  assign clk_fall = ~clk_f & clk_prev_q;

  state_e                  state_q;
  logic [2:0]              bit_cnt_q;
  logic [6:0]              shift_q;
  logic [3:0]              addr_q;
  logic                    fixed_q;
  logic                    disp_on_q;
  logic [2:0]              bright_q;
  logic                    oe_q;
  logic                    dout_q;
  logic [NumKeyBits-1:0]   snap_q;
  logic [RdCntW-1:0]       rd_cnt_q;
  logic                    byte_seen_q;
  logic                    frame_done_q;
  logic                    cmd_error_q;
  logic [7:0]              rd_data_q;
  logic [7:0]              ram_q [16];

  logic [7:0] byte_w;
  logic       byte_done;

  // Bits arrive LSB first, so the completing bit is the MSB.
  assign byte_w    = {dio_f, shift_q};
  assign byte_done = clk_rise & (bit_cnt_q == 3'd7);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      addr_q       <= '0;
      fixed_q      <= 1'b0;
      disp_on_q    <= 1'b0;
      bright_q     <= '0;
      oe_q         <= 1'b0;
      dout_q       <= 1'b1;
      snap_q       <= '0;
      rd_cnt_q     <= '0;
      byte_seen_q  <= 1'b0;
      frame_done_q <= 1'b0;
      cmd_error_q  <= 1'b0;
      rd_data_q    <= '0;
      for (int i = 0; i < 16; i++) begin
        ram_q[i] <= '0;
      end
    end else begin
      frame_done_q <= 1'b0;
      cmd_error_q  <= 1'b0;
      rd_data_q    <= ram_q[rd_addr];

      // Strobe edges take priority over any clock edge seen in the same cycle.
      if (stb_rise) begin
        state_q      <= StIdle;
        bit_cnt_q    <= '0;
        oe_q         <= 1'b0;
        dout_q       <= 1'b1;
        frame_done_q <= byte_seen_q;
        byte_seen_q  <= 1'b0;
      end else if (stb_fall) begin
        state_q     <= StCmd;
        bit_cnt_q   <= '0;
        oe_q        <= 1'b0;
        dout_q      <= 1'b1;
        byte_seen_q <= 1'b0;
      end else begin
        unique case (state_q)
          StCmd: begin
            if (clk_rise) begin
              shift_q   <= {dio_f, shift_q[6:1]};
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
            if (byte_done) begin
              byte_seen_q <= 1'b1;
              unique case (byte_w[7:6])
                2'b01: begin
                  if (byte_w[1]) begin
                    snap_q   <= keys;
                    rd_cnt_q <= '0;
                    oe_q     <= 1'b1;
                    dout_q   <= 1'b1;
                    state_q  <= StRdata;
                  end else begin
                    fixed_q <= byte_w[2];
                    state_q <= StDrain;
                  end
                end
                2'b10: begin
                  disp_on_q <= byte_w[3];
                  bright_q  <= byte_w[2:0];
                  state_q   <= StDrain;
                end
                2'b11: begin
                  addr_q  <= byte_w[3:0];
                  state_q <= StWdata;
                end
                default: begin
                  cmd_error_q <= 1'b1;
                  state_q     <= StDrain;
                end
              endcase
            end
          end
          StWdata: begin
            if (clk_rise) begin
              shift_q   <= {dio_f, shift_q[6:1]};
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
            if (byte_done) begin
              byte_seen_q    <= 1'b1;
              ram_q[addr_q]  <= byte_w;
              if (!fixed_q) begin
                addr_q <= addr_q + 4'd1;
              end
            end
          end
          StRdata: begin
            // Release DIO on the rise that lets the host sample the final bit.
            if (clk_fall && (rd_cnt_q != RdCntW'(NumKeyBits))) begin
              dout_q   <= snap_q[0];
              snap_q   <= snap_q >> 1;
              rd_cnt_q <= rd_cnt_q + RdCntW'(1);
            end else if (clk_rise && (rd_cnt_q == RdCntW'(NumKeyBits))) begin
              oe_q    <= 1'b0;
              dout_q  <= 1'b1;
              state_q <= StDrain;
            end
          end
          StIdle, StDrain: begin
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign tm_dio_out = dout_q;
  assign tm_dio_oe  = oe_q;
  assign rd_data    = rd_data_q;
  assign display_on = disp_on_q;
  assign brightness = bright_q;
  assign frame_done = frame_done_q;
  assign cmd_error  = cmd_error_q;

endmodule
